seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//   Scan controller for the 4-digit seven-segment display driven by the processor core.
//   Accepts a 16-bit display word over a valid/ready handshake and holds it in a pending register.
//   Commits the pending word at frame boundaries only, so a frame never shows a mix of old and new digits.
//   Time-multiplexes the 4 digits onto the shared SEG/AN pins, with an anode-off guard band at the start of each slot.
// PARAMETERS
//   TICK_DIV      50000  clock cycles per digit slot, guard included; legal range >= BLANK_CYCLES+1
//   BLANK_CYCLES  4      cycles at the start of each slot with all anodes off (anti-ghosting)
//   AN_ACT_LOW    1      1: anode asserted = 0; 0: asserted = 1
//   SEG_ACT_LOW   1      1: segment lit = 0; 0: lit = 1
// PORTS
//   clk         in   1   clock; the only clock
//   rst_n       in   1   reset, synchronous, active-low
//   enable      in   1   1: scan the display; 0: all anodes and segments off
//   load_valid  in   1   requester offers load_data
//   load_ready  out  1   pending register free; transfer happens on valid&ready at posedge
//   load_data   in   16  hex word; [3:0] = digit 0 (rightmost, an[0]) ... [15:12] = digit 3
//   dp_mask     in   4   per-digit decimal point, bit i = digit i; sampled live, not shadowed
//   blank_lz    in   1   1: blank leading zero digits
//   seg         out  8   {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   an          out  4   one-hot digit select, polarity set by AN_ACT_LOW
//   digit_idx   out  2   index of the digit currently being driven
//   frame_done  out  1   1-cycle pulse at the end of the digit-3 slot
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     - an and seg all deasserted (0xF / 0xFF when active-low); digit_idx=0; frame_done=0; load_ready=1.
//     - display and pending registers cleared; FSM to IDLE; slot counter cnt=0.
//     - A reset mid-frame aborts the frame and drops any pending word.
//   FSM states and transitions:
//     - IDLE (enable=0): cnt=0, digit=0; if pending is full, commit it to display next cycle.
//     - IDLE -> GUARD on enable=1.
//     - GUARD: cnt < BLANK_CYCLES; anodes off, segments off.
//     - GUARD -> DRIVE when cnt reaches BLANK_CYCLES.
//     - DRIVE: BLANK_CYCLES <= cnt < TICK_DIV; an[digit] asserted; seg = decoded digit.
//     - At cnt=TICK_DIV-1: cnt->0, digit->digit+1 (wraps 3->0), state->GUARD.
//     - enable=0 in any state: IDLE next cycle; outputs off.
//   Latency: an, seg and digit_idx are registered, 1 cycle behind the FSM state.
//   Frame boundary (the cycle cnt=TICK_DIV-1 with digit=3):
//     - frame_done=1 for exactly 1 cycle.
//     - if pending is full, display<=pending on that edge; load_ready=1 from the next cycle.
//   Handshake:
//     - accept on load_valid & load_ready; load_ready drops the cycle after acceptance.
//     - load_data is ignored while ready=0; the requester must hold valid.
//     - accept and frame boundary on the same edge: the new word goes to pending;
//       the old pending (if any) commits to display; the new word waits for the next boundary.
//   Decode (active-high before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//     8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; bit7 = dp_mask[digit].
//   Leading-zero blanking (blank_lz=1):
//     - digit i (i=3..1) is blanked if it and all higher digits are 0; digit 0 is never blanked.
//     - a blanked digit keeps its anode slot and its dp; the 7 segments are off.
// TESTING
//   TICK_DIV=8 BLANK_CYCLES=2, active-low; load 16'h12AF -> digit0 slot: an=4'b1110 seg=8'h8E; digit3: an=4'b0111 seg=8'hF9
//   Timing: each slot shows an=4'hF for 2 cycles then one anode for 6 cycles; frame_done pulses every 32 cycles
//   Load 16'h0005, blank_lz=1, dp_mask=4'b0100 -> digit0 seg=8'h92; digit1 seg=8'hFF; digit2 seg=8'h7F; digit3 seg=8'hFF
//   Load 16'h0000, blank_lz=1 -> digit0 seg=8'hC0 shown; digits 3..1 seg=8'hFF
//   Two loads mid-frame -> first accepted; ready=0; second held until the boundary; display changes only after frame_done
//   enable 1->0 mid-slot -> next cycle an=4'hF seg=8'hFF; re-enable restarts at digit0 GUARD
//   rst_n=0 for 1 cycle mid-DRIVE -> next cycle all outputs at reset values; pending dropped; display shows 0000

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Load channel for the display word: valid/ready handshake.
// A word moves on a rising clk edge where load_valid & load_ready are both 1; the
// requester holds load_valid and load_data steady until that edge, and the
// receiver ignores load_data whenever load_ready is 0.
interface seg7_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with a one-deep pending word that is
// committed only at frame boundaries, so a frame never mixes old and new digits.
module seg7_scan_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter bit AN_ACT_LOW   = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [3:0]              i_dp_mask,
    input  logic                    i_blank_lz,
    seg7_scan_ctrl_if.slave         load_if,
    output logic [7:0]              o_seg,
    output logic [3:0]              o_an,
    output logic [1:0]              o_digit_idx,
    output logic                    o_frame_done,
    output logic [1:0]              o_dbg_state
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] AN_OFF  = AN_ACT_LOW  ? 4'hF  : 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // With no guard band a slot starts directly in DRIVE.
    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_GUARD;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [1:0]    r_digit, w_digit_nx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pend_full;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;
    logic [1:0]    r_digit_idx;

    logic          w_frame_end;
    logic          w_accept;
    logic          w_commit;
    logic          w_drive;
    logic [3:0]    w_nib;
    logic          w_lz_blank;
    logic [7:0]    w_seg_ah;
    logic [3:0]    w_an_ah;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign w_frame_end = (r_state == ST_DRIVE) && (r_cnt == CW'(TICK_DIV - 1)) && (r_digit == 2'd3);
    assign w_accept    = load_if.load_valid && !r_pend_full;
    assign w_commit    = r_pend_full && (w_frame_end || (r_state == ST_IDLE));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_digit_nx = r_digit;
        if (!i_enable) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_digit_nx = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = SLOT_START;
                    w_cnt_nx   = '0;
                    w_digit_nx = 2'd0;
                end
                ST_GUARD: begin
                    w_cnt_nx = r_cnt + 1'b1;
                    if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                        w_state_nx = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == CW'(TICK_DIV - 1)) begin
                        w_cnt_nx   = '0;
                        w_digit_nx = r_digit + 2'd1;
                        w_state_nx = SLOT_START;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_digit_nx = 2'd0;
                end
            endcase
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    assign w_nib      = r_disp[{r_digit, 2'b00} +: 4];
    assign w_lz_blank = i_blank_lz && (r_digit != 2'd0) && ((r_disp >> {r_digit, 2'b00}) == 16'd0);
    assign w_drive    = i_enable && (r_state == ST_DRIVE);
    assign w_seg_ah   = w_drive ? {i_dp_mask[r_digit], (w_lz_blank ? 7'd0 : f_decode(w_nib))} : 8'd0;
    assign w_an_ah    = w_drive ? (4'd1 << r_digit) : 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_digit     <= 2'd0;
            r_disp      <= 16'd0;
            r_pend      <= 16'd0;
            r_pend_full <= 1'b0;
            r_seg       <= SEG_OFF;
            r_an        <= AN_OFF;
            r_digit_idx <= 2'd0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_digit     <= w_digit_nx;
            r_seg       <= w_seg_ah ^ SEG_OFF;
            r_an        <= w_an_ah ^ AN_OFF;
            r_digit_idx <= r_digit;
            if (w_commit) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pend      <= load_if.load_data;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign load_if.load_ready = !r_pend_full;
    assign o_seg              = r_seg;
    assign o_an               = r_an;
    assign o_digit_idx        = r_digit_idx;
    assign o_frame_done       = w_frame_end;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a cycle-position reference model checks every output each
// cycle, with directed display scenarios followed by randomized traffic.
module tb_seg7_scan_ctrl;

    localparam int T     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * T;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       blank_lz = 1'b0;
    logic [3:0] dp_mask = 4'd0;
    logic [7:0] seg;
    logic [3:0] an;
    logic [1:0] didx;
    logic       fdone;
    logic [1:0] dbg_state;

    seg7_scan_ctrl_if lif();

    seg7_scan_ctrl #(
        .TICK_DIV(T), .BLANK_CYCLES(B), .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_dp_mask(dp_mask),
        .i_blank_lz(blank_lz), .load_if(lif), .o_seg(seg), .o_an(an),
        .o_digit_idx(didx), .o_frame_done(fdone), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: scan position p counts cycles since scanning began.
    logic [15:0] exp_q[$];
    logic [15:0] m_disp;
    logic [15:0] m_sh;
    logic [6:0]  m_s;
    bit          m_active, m_ok, m_acc, m_com, m_bnd;
    int          m_p, m_d;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic [1:0]  e_didx;
    logic        e_fd;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_p      = 0;
            m_disp   = 16'd0;
            exp_q.delete();
            e_seg    = 8'hFF;
            e_an     = 4'hF;
            e_didx   = 2'd0;
        end else begin
            m_d    = m_active ? (m_p / T) % 4 : 0;
            m_bnd  = m_active && ((m_p % FRAME) == FRAME - 1);
            e_didx = m_d[1:0];
            if (enable && m_active && ((m_p % T) >= B)) begin
                m_sh = m_disp >> (4 * m_d);
                m_s  = SEG_TAB[m_sh[3:0]];
                if (blank_lz && m_d != 0 && m_sh == 16'd0) m_s = 7'd0;
                e_seg = ~{dp_mask[m_d], m_s};
                e_an  = ~(4'd1 << m_d);
            end else begin
                e_seg = 8'hFF;
                e_an  = 4'hF;
            end
            m_acc = lif.load_valid && (exp_q.size() == 0);
            m_com = (exp_q.size() != 0) && (!m_active || m_bnd);
            if (m_com) m_disp = exp_q.pop_front();
            if (m_acc) exp_q.push_back(lif.load_data);
            if (!enable) begin
                m_active = 1'b0;
                m_p      = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_p      = 0;
            end else begin
                m_p++;
            end
        end
        e_fd = m_active && ((m_p % FRAME) == FRAME - 1);
        m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("digit_idx", didx, e_didx);
            chk("frame_done", fdone, e_fd);
            chk("load_ready", lif.load_ready, exp_q.size() == 0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w, input int maxc);
        int i;
        i = 0;
        lif.load_valid = 1'b1;
        lif.load_data  = w;
        while (!lif.load_ready && i < maxc) begin
            @(negedge clk);
            i++;
        end
        if (!lif.load_ready) chk("load_timeout", lif.load_ready, 1);
        else @(negedge clk);
        lif.load_valid = 1'b0;
        lif.load_data  = 16'($urandom);
    endtask

    task automatic wait_fdone();
        int i;
        i = 0;
        @(negedge clk);
        while (!fdone && i < FRAME + 4) begin
            @(negedge clk);
            i++;
        end
        if (!fdone) chk("fdone_wait", fdone, 1);
    endtask

    task automatic wait_digit(input int d, input logic [7:0] exp_seg, input string tag);
        logic [3:0] want;
        int i;
        want = ~(4'd1 << d);
        i = 0;
        while (an !== want && i < FRAME + 8) begin
            @(negedge clk);
            i++;
        end
        if (an !== want) chk({tag, "_an"}, an, want);
        else chk(tag, seg, exp_seg);
    endtask

    task automatic wait_drive();
        int i;
        i = 0;
        while (an === 4'hF && i < 2 * T) begin
            @(negedge clk);
            i++;
        end
        if (an === 4'hF) chk("drive_wait", an, 4'hE);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int k = 0; k < 4; k++) begin
            w[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        end
        return w;
    endfunction

    initial begin
        int n;
        int r;
        bit fire;
        lif.load_valid = 1'b0;
        lif.load_data  = 16'd0;

        cycles(2);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_didx", didx, 2'd0);
        chk("rst_fdone", fdone, 1'b0);
        chk("rst_ready", lif.load_ready, 1'b1);
        rst_n = 1'b1;

        send(16'h12AF, 4);
        enable = 1'b1;
        wait_digit(0, 8'h8E, "hex_d0");
        wait_digit(3, 8'hF9, "hex_d3");

        wait_fdone();
        n = 0;
        @(negedge clk);
        n++;
        while (!fdone && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fdone_period", n, FRAME);

        blank_lz = 1'b1;
        dp_mask  = 4'b0100;
        send(16'h0005, FRAME + 8);
        wait_fdone();
        wait_digit(0, 8'h92, "lz5_d0");
        wait_digit(1, 8'hFF, "lz5_d1");
        wait_digit(2, 8'h7F, "lz5_d2");
        wait_digit(3, 8'hFF, "lz5_d3");

        dp_mask = 4'b0000;
        send(16'h0000, FRAME + 8);
        wait_fdone();
        wait_digit(0, 8'hC0, "lz0_d0");
        wait_digit(1, 8'hFF, "lz0_d1");
        wait_digit(2, 8'hFF, "lz0_d2");
        wait_digit(3, 8'hFF, "lz0_d3");

        blank_lz = 1'b0;
        send(16'h1111, FRAME + 8);
        send(16'h2222, FRAME + 8);
        wait_digit(0, 8'hF9, "two_first");
        wait_fdone();
        wait_digit(0, 8'hA4, "two_second");

        wait_drive();
        enable = 1'b0;
        cycles(1);
        chk("dis_an", an, 4'hF);
        chk("dis_seg", seg, 8'hFF);
        cycles(2);
        enable = 1'b1;
        cycles(3);
        chk("reen_guard_an", an, 4'hF);
        cycles(1);
        chk("reen_d0_an", an, 4'hE);
        chk("reen_d0_idx", didx, 2'd0);

        send(16'h4444, 4);
        wait_drive();
        rst_n = 1'b0;
        cycles(1);
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_ready", lif.load_ready, 1'b1);
        rst_n = 1'b1;
        wait_digit(0, 8'hC0, "post_rst_d0");
        wait_digit(3, 8'hC0, "post_rst_d3");
        wait_fdone();
        wait_digit(0, 8'hC0, "post_rst_drop");

        fire = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if (fire) lif.load_valid = 1'b0;
            r = $urandom_range(0, 199);
            if (r < 3) enable = ~enable;
            else if (r < 5) rst_n = 1'b0;
            else if (r < 15) dp_mask = 4'($urandom);
            else if (r < 20) blank_lz = ~blank_lz;
            else if (r < 40 && !lif.load_valid) begin
                lif.load_valid = 1'b1;
                lif.load_data  = rand_word();
            end
            if (r >= 190 && !enable) enable = 1'b1;
            fire = lif.load_valid && lif.load_ready;
        end
        @(negedge clk);
        lif.load_valid = 1'b0;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
